// File: rtl/sys_ctrl.sv
// System-control bus slave: 64-bit cycle counter, scratch register and a pass/fail exit code
// whose shutdown command raises o_shutdown after a drain delay.
module sys_ctrl #(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned DRAIN_CYCLES = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_stb,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_sel,
  output logic              o_ack,
  output logic [31:0]       o_rdata,
  output logic              o_shutdown,
  output logic [15:0]       o_exit_code
);

  localparam int unsigned IdxW = ADDR_W - 2;
  localparam logic [IdxW-1:0]  IdxCtrl    = IdxW'(0);
  localparam logic [IdxW-1:0]  IdxMtimeL  = IdxW'(1);
  localparam logic [IdxW-1:0]  IdxMtimeH  = IdxW'(2);
  localparam logic [IdxW-1:0]  IdxScratch = IdxW'(3);
  localparam logic [CNT_W-1:0] DrainLoad  = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ack_q;
  logic [31:0]       rdata_q, rdata_d;
  logic [63:0]       mtime_q;
  logic [31:0]       mtime_hi_q;
  logic [31:0]       scratch_q, scratch_d;
  logic [15:0]       exit_code_q, exit_code_d;

  logic              acc, rd_acc, wr_acc;
  logic [IdxW-1:0]   idx;
  logic              cmd_pass, cmd_fail, cmd_valid;
  logic              cmd_en, shutdown;

  // A request seen during its own ack cycle is the master still holding stb; ignore it.
  assign acc       = i_stb & ~ack_q;
  assign rd_acc    = acc & ~i_we;
  assign wr_acc    = acc & i_we;
  assign idx       = i_addr[ADDR_W-1:2];
  assign cmd_pass  = (i_wdata[15:0] == 16'h5555);
  assign cmd_fail  = (i_wdata[15:0] == 16'h3333);
  assign cmd_valid = wr_acc && (idx == IdxCtrl) && (i_sel == 4'hF) && (cmd_pass || cmd_fail);

  // FSM state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (cmd_en) begin
          state_d = StDrain;
          cnt_d   = DrainLoad;
        end
      end
      StDrain: begin
        if (cnt_q == '0) begin
          state_d = StHalt;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
  end

  // FSM outputs: only the first command taken in RUN counts
  always_comb begin
    shutdown = (state_q == StHalt);
    cmd_en   = (state_q == StRun) && cmd_valid;
  end

  always_comb begin
    rdata_d = '0;
    if (rd_acc) begin
      if (idx == IdxCtrl) begin
        rdata_d = {15'b0, shutdown, exit_code_q};
      end else if (idx == IdxMtimeL) begin
        rdata_d = mtime_q[31:0];
      end else if (idx == IdxMtimeH) begin
        rdata_d = mtime_hi_q;
      end else if (idx == IdxScratch) begin
        rdata_d = scratch_q;
      end
    end
  end

  always_comb begin
    scratch_d = scratch_q;
    if (wr_acc && (idx == IdxScratch)) begin
      for (int b = 0; b < 4; b++) begin
        if (i_sel[b]) begin
          scratch_d[8*b +: 8] = i_wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    exit_code_d = exit_code_q;
    if (cmd_en) begin
      exit_code_d = cmd_pass ? 16'h0000 : i_wdata[31:16];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      mtime_q     <= '0;
      mtime_hi_q  <= '0;
      scratch_q   <= '0;
      exit_code_q <= '0;
    end else begin
      ack_q       <= acc;
      rdata_q     <= rdata_d;
      mtime_q     <= mtime_q + 64'd1;
      scratch_q   <= scratch_d;
      exit_code_q <= exit_code_d;
      // High word is snapshotted with the low word so a two-read 64-bit access is atomic.
      if (rd_acc && (idx == IdxMtimeL)) begin
        mtime_hi_q <= mtime_q[63:32];
      end
    end
  end

  assign o_ack       = ack_q;
  assign o_rdata     = rdata_q;
  assign o_shutdown  = shutdown;
  assign o_exit_code = exit_code_q;

endmodule

// File: tb/tb_sys_ctrl.sv
// Self-checking bench for sys_ctrl: directed register/shutdown scenarios plus random
// register traffic compared against a behavioural model of the register map.
module tb_sys_ctrl;

  localparam int unsigned D = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  sel = '0;
  logic        ack;
  logic [31:0] rdata;
  logic        shutdown;
  logic [15:0] exit_code;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Model state
  logic [63:0] cyc_q;
  logic [63:0] off = '0;
  logic [31:0] scr_m = '0;
  logic [31:0] hi_m = '0;
  logic [15:0] ec_m = '0;
  logic        sh_m = 1'b0;
  wire  [63:0] ref_mtime = cyc_q + off;

  always #5 clk = ~clk;

  // Counts rising edges since reset release: the architectural value of mtime.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_q <= '0;
    else        cyc_q <= cyc_q + 64'd1;
  end

  sys_ctrl #(.ADDR_W(4), .DRAIN_CYCLES(D), .CNT_W(8)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_stb       (stb),
    .i_we        (we),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .i_sel       (sel),
    .o_ack       (ack),
    .o_rdata     (rdata),
    .o_shutdown  (shutdown),
    .o_exit_code (exit_code)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bus transfer; returns one cycle after the ack cycle, #1 past the edge.
  task automatic xfer(input logic w, input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic [63:0] mt);
    @(negedge clk);
    stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
    mt = ref_mtime;
    @(posedge clk); #1;
    check("ack_rise", {63'b0, ack}, 64'd1);
    rd  = rdata;
    stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("ack_fall", {63'b0, ack}, 64'd0);
  endtask

  task automatic model_read(input logic [1:0] idx, input logic [63:0] mt, output logic [31:0] e);
    case (idx)
      2'd0: e = {15'b0, sh_m, ec_m};
      2'd1: begin e = mt[31:0]; hi_m = mt[63:32]; end
      2'd2: e = hi_m;
      default: e = scr_m;
    endcase
  endtask

  task automatic model_write(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] s);
    if (idx == 2'd3) begin
      for (int b = 0; b < 4; b++) if (s[b]) scr_m[8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a);
    logic [31:0] rd, e;
    logic [63:0] mt;
    xfer(1'b0, a, 32'h0, 4'h0, rd, mt);
    model_read(a[3:2], mt, e);
    check(tag, {32'b0, rd}, {32'b0, e});
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    logic [63:0] mt;
    xfer(1'b1, a, d, s, rd, mt);
    model_write(a[3:2], d, s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    off = '0; scr_m = '0; hi_m = '0; ec_m = '0; sh_m = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, e, d;
    logic [63:0] mt;
    logic [3:0]  a, s;
    logic        w;

    // 1: reset state
    do_reset();
    #1;
    check("rst_ack", {63'b0, ack}, 64'd0);
    check("rst_rdata", {32'b0, rdata}, 64'd0);
    check("rst_shutdown", {63'b0, shutdown}, 64'd0);
    check("rst_exit", {48'b0, exit_code}, 64'd0);
    rd_chk("rst_scratch", 4'hC);

    // 2: partial byte-enable write
    wr(4'hC, 32'hDEAD_BEEF, 4'b0011);
    rd_chk("scratch_sel", 4'hC);
    check("scratch_sel_const", {32'b0, scr_m}, 64'h0000_BEEF);

    // Random register traffic; CTRL writes carry a non-command code
    for (int i = 0; i < 150; i++) begin
      a = 4'($urandom_range(0, 15));
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if (w && a[3:2] == 2'd0) d[15:0] = 16'h0000;
      xfer(w, a, d, s, rd, mt);
      if (w) begin
        model_write(a[3:2], d, s);
      end else begin
        model_read(a[3:2], mt, e);
        check("rand_rd", {32'b0, rd}, {32'b0, e});
      end
    end
    check("rand_no_shutdown", {63'b0, shutdown}, 64'd0);

    // 3: atomic mtime read, including a carry into the high word
    rd_chk("mtime_l", 4'h4);
    rd_chk("mtime_h", 4'h8);
    @(negedge clk);
    force dut.mtime_q = 64'h0000_0000_FFFF_FFFE;
    off = 64'h0000_0000_FFFF_FFFE - cyc_q;
    #1;
    release dut.mtime_q;
    rd_chk("wrap_l", 4'h4);
    check("wrap_hi_model", {32'b0, hi_m}, 64'd0);
    rd_chk("wrap_h_latched", 4'h8);
    rd_chk("wrap_l2", 4'h4);
    rd_chk("wrap_h2", 4'h8);
    check("wrap_hi_model2", {32'b0, hi_m}, 64'd1);

    // 4: PASS command, shutdown exactly D cycles after the ack cycle
    wr(4'h0, 32'h0007_5555, 4'hF);
    check("pass_exit", {48'b0, exit_code}, 64'd0);
    cycles(D - 2);
    check("pass_sd_early", {63'b0, shutdown}, 64'd0);
    cycles(1);
    check("pass_sd_on", {63'b0, shutdown}, 64'd1);
    sh_m = 1'b1;
    rd_chk("pass_ctrl", 4'h0);
    cycles(10);
    check("pass_sd_sticky", {63'b0, shutdown}, 64'd1);

    // 5: FAIL command wins over a later PASS during DRAIN
    do_reset();
    wr(4'h0, 32'h002A_3333, 4'hF);
    ec_m = 16'h002A;
    check("fail_exit_ack", {48'b0, exit_code}, 64'h2A);
    wr(4'h0, 32'h0000_5555, 4'hF);
    rd_chk("drain_scratch", 4'hC);
    cycles(D - 6);
    check("fail_sd_early", {63'b0, shutdown}, 64'd0);
    cycles(1);
    check("fail_sd_on", {63'b0, shutdown}, 64'd1);
    check("fail_exit", {48'b0, exit_code}, 64'h2A);
    sh_m = 1'b1;
    rd_chk("fail_ctrl", 4'h0);

    // 6: malformed commands ignored; reset mid-DRAIN aborts the shutdown
    do_reset();
    wr(4'h0, 32'h0000_5555, 4'h3);
    wr(4'h0, 32'h0000_1234, 4'hF);
    cycles(D + 10);
    check("bad_cmd_sd", {63'b0, shutdown}, 64'd0);
    rd_chk("bad_cmd_ctrl", 4'h0);
    wr(4'h0, 32'h0077_3333, 4'hF);
    check("abort_exit", {48'b0, exit_code}, 64'h77);
    cycles(5);
    @(negedge clk);
    rst_n = 1'b0;
    off = '0; scr_m = '0; hi_m = '0; ec_m = '0; sh_m = 1'b0;
    #1;
    check("abort_rst_sd", {63'b0, shutdown}, 64'd0);
    check("abort_rst_exit", {48'b0, exit_code}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(D + 20);
    check("abort_sd", {63'b0, shutdown}, 64'd0);
    rd_chk("abort_ctrl", 4'h0);
    rd_chk("abort_mtime", 4'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
